// File: rtl/control_fsm_if.sv
// Memory request channel between the main controller and the memory port.
// Handshake: the controller raises mem_valid (with mem_we and addr_sel) and
// holds all three stable until memory answers with mem_ready in the same
// cycle; that cycle completes the access. mem_ready is ignored whenever
// mem_valid is low.
interface control_fsm_if;
   logic mem_valid;
   logic mem_we;
   logic addr_sel;
   logic mem_ready;

   modport master (
      output mem_valid,
      output mem_we,
      output addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_we,
      input  addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle main controller for the RV32I core. It runs one instruction at
// a time through fetch, decode, execute, memory and writeback, and drives
// every datapath select and write enable plus the ALU command. The outputs
// are decoded combinationally from the state and the IR, and they are all
// held at zero while resetn is low.
module control_fsm (
   input  logic                clk,
   input  logic                resetn,
   control_fsm_if.master       mem,
   input  logic [31:0]         instr,
   input  logic                branch_flag,
   output logic                ir_we,
   output logic                mdr_we,
   output logic                pc_we,
   output logic                pc_src,
   output logic                rf_we,
   output logic [1:0]          wb_sel,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [3:0]          alu_ctrl,
   output logic [2:0]          imm_sel,
   output logic                illegal,
   output logic [3:0]          state
);

   // State encodings
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_WB_ALU   = 4'd4;
   localparam logic [3:0] S_MEM_ADDR = 4'd5;
   localparam logic [3:0] S_MEM_RD   = 4'd6;
   localparam logic [3:0] S_WB_MEM   = 4'd7;
   localparam logic [3:0] S_MEM_WR   = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_LUI      = 4'd12;
   localparam logic [3:0] S_AUIPC    = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd15;

   // ALU commands (same values as ALU_CMD_* in constants.v)
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   // Opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // Datapath select encodings
   localparam logic [1:0] A_PC    = 2'd0;
   localparam logic [1:0] A_RS1   = 2'd1;
   localparam logic [1:0] A_OLDPC = 2'd2;
   localparam logic [1:0] B_RS2   = 2'd0;
   localparam logic [1:0] B_IMM   = 2'd1;
   localparam logic [1:0] B_FOUR  = 2'd2;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MDR  = 2'd1;
   localparam logic [1:0] WB_PC   = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;
   localparam logic [2:0] IMM_I   = 3'd0;
   localparam logic [2:0] IMM_S   = 3'd1;
   localparam logic [2:0] IMM_B   = 3'd2;
   localparam logic [2:0] IMM_U   = 3'd3;
   localparam logic [2:0] IMM_J   = 3'd4;

   logic [3:0] state_q, state_d, decode_target;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       taken;

   logic       mem_valid_c, mem_we_c, addr_sel_c;
   logic       ir_we_c, mdr_we_c, pc_we_c, pc_src_c, rf_we_c, illegal_c;
   logic [1:0] wb_sel_c, alu_src_a_c, alu_src_b_c;
   logic [3:0] alu_ctrl_c;
   logic [2:0] imm_sel_c;

   // Register and rd fields are consumed by the datapath, not here
   logic unused_fields;
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // BEQ/BLT/BLTU take on flag, BNE/BGE/BGEU on its inverse
   assign taken = funct3[0] ? ~branch_flag : branch_flag;

   // funct3 to ALU command for register and immediate arithmetic
   function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                         input logic       use_sub,
                                         input logic       use_sra);
      logic [3:0] op;
      case (f3)
         3'd0:    op = use_sub ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = use_sra ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Decode the IR into the first execute state, trapping on encodings the core does not implement
   always_comb begin
      decode_target = S_TRAP;
      case (opcode)
         OP_R: begin
            if ((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))))
               decode_target = S_EXEC_R;
         end
         OP_I: begin
            if (funct3 == 3'd1)
               decode_target = (funct7 == 7'h00) ? S_EXEC_I : S_TRAP;
            else if (funct3 == 3'd5)
               decode_target = ((funct7 == 7'h00) || (funct7 == 7'h20)) ? S_EXEC_I : S_TRAP;
            else
               decode_target = S_EXEC_I;
         end
         OP_LOAD, OP_STORE: begin
            if (funct3 == 3'b010)
               decode_target = S_MEM_ADDR;
         end
         OP_BRANCH: begin
            if ((funct3 != 3'd2) && (funct3 != 3'd3))
               decode_target = S_BRANCH;
         end
         OP_JAL:   decode_target = S_JAL;
         OP_JALR: begin
            if (funct3 == 3'd0)
               decode_target = S_JALR;
         end
         OP_LUI:   decode_target = S_LUI;
         OP_AUIPC: decode_target = S_AUIPC;
         OP_FENCE: decode_target = S_FETCH;
         default:  decode_target = S_TRAP;
      endcase
   end

   // Next-state selection; memory states hold until mem_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   state_d = decode_target;
         S_EXEC_R,
         S_EXEC_I:   state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = mem.mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   state_d = mem.mem_ready ? S_FETCH : S_MEM_WR;
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC:
                     state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase
   end

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   // Per-state datapath controls; anything not set for a state stays 0
   always_comb begin
      mem_valid_c = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = 1'b0;
      ir_we_c     = 1'b0;
      mdr_we_c    = 1'b0;
      pc_we_c     = 1'b0;
      pc_src_c    = 1'b0;
      rf_we_c     = 1'b0;
      illegal_c   = 1'b0;
      wb_sel_c    = WB_ALU;
      alu_src_a_c = A_PC;
      alu_src_b_c = B_RS2;
      alu_ctrl_c  = ALU_ADD;
      imm_sel_c   = IMM_I;
      case (state_q)
         S_FETCH: begin
            mem_valid_c = 1'b1;
            addr_sel_c  = 1'b0;
            alu_src_a_c = A_PC;
            alu_src_b_c = B_FOUR;
            pc_src_c    = 1'b0;
            ir_we_c     = mem.mem_ready;
            pc_we_c     = mem.mem_ready;
         end
         S_DECODE: begin
            alu_src_a_c = A_OLDPC;
            alu_src_b_c = B_IMM;
            case (opcode)
               OP_BRANCH: imm_sel_c = IMM_B;
               OP_JAL:    imm_sel_c = IMM_J;
               OP_AUIPC:  imm_sel_c = IMM_U;
               default:   imm_sel_c = IMM_I;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a_c = A_RS1;
            alu_src_b_c = B_RS2;
            alu_ctrl_c  = alu_op(funct3, funct7[5], funct7[5]);
         end
         S_EXEC_I: begin
            alu_src_a_c = A_RS1;
            alu_src_b_c = B_IMM;
            imm_sel_c   = IMM_I;
            alu_ctrl_c  = alu_op(funct3, 1'b0, funct7[5]);
         end
         S_WB_ALU: begin
            rf_we_c  = 1'b1;
            wb_sel_c = WB_ALU;
         end
         S_MEM_ADDR: begin
            alu_src_a_c = A_RS1;
            alu_src_b_c = B_IMM;
            imm_sel_c   = (opcode == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_RD: begin
            addr_sel_c  = 1'b1;
            mem_valid_c = 1'b1;
            mdr_we_c    = mem.mem_ready;
         end
         S_WB_MEM: begin
            rf_we_c  = 1'b1;
            wb_sel_c = WB_MDR;
         end
         S_MEM_WR: begin
            addr_sel_c  = 1'b1;
            mem_valid_c = 1'b1;
            mem_we_c    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c = A_RS1;
            alu_src_b_c = B_RS2;
            alu_ctrl_c  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            pc_we_c     = taken;
            pc_src_c    = 1'b1;
         end
         S_JAL: begin
            rf_we_c  = 1'b1;
            wb_sel_c = WB_PC;
            pc_we_c  = 1'b1;
            pc_src_c = 1'b1;
         end
         S_JALR: begin
            alu_src_a_c = A_RS1;
            alu_src_b_c = B_IMM;
            imm_sel_c   = IMM_I;
            pc_src_c    = 1'b0;
            pc_we_c     = 1'b1;
            rf_we_c     = 1'b1;
            wb_sel_c    = WB_PC;
         end
         S_LUI: begin
            rf_we_c   = 1'b1;
            wb_sel_c  = WB_IMM;
            imm_sel_c = IMM_U;
         end
         S_AUIPC: begin
            rf_we_c  = 1'b1;
            wb_sel_c = WB_ALU;
         end
         S_TRAP: begin
            illegal_c = 1'b1;
         end
         default: begin
            illegal_c = 1'b0;
         end
      endcase
   end

   // Hold every output at zero while reset is asserted
   assign mem.mem_valid = resetn & mem_valid_c;
   assign mem.mem_we    = resetn & mem_we_c;
   assign mem.addr_sel  = resetn & addr_sel_c;
   assign ir_we         = resetn & ir_we_c;
   assign mdr_we        = resetn & mdr_we_c;
   assign pc_we         = resetn & pc_we_c;
   assign pc_src        = resetn & pc_src_c;
   assign rf_we         = resetn & rf_we_c;
   assign illegal       = resetn & illegal_c;
   assign wb_sel        = resetn ? wb_sel_c    : 2'd0;
   assign alu_src_a     = resetn ? alu_src_a_c : 2'd0;
   assign alu_src_b     = resetn ? alu_src_b_c : 2'd0;
   assign alu_ctrl      = resetn ? alu_ctrl_c  : 4'd0;
   assign imm_sel       = resetn ? imm_sel_c   : 3'd0;
   assign state         = resetn ? state_q     : S_FETCH;

endmodule
